// File: rtl/mips32_pkg.sv
// Shared MIPS32 core constants and the register-dump FSM state type.
package mips32_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/mips32_reg_dump_if.sv
// Register-file dump port plus the outgoing beat stream of the dump engine.
interface mips32_reg_dump_if
    import mips32_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W,
    parameter int unsigned IDX_W  = REG_IDX_W
);

    logic              halted;
    logic              rf_rd_en;
    logic [IDX_W-1:0]  rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [IDX_W-1:0]  dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              busy;
    logic              done;

    modport master (
        input  halted, rf_rd_data, dump_ready,
        output rf_rd_en, rf_rd_addr, dump_valid, dump_idx, dump_data,
               dump_last, busy, done
    );

    modport slave (
        output halted, rf_rd_data, dump_ready,
        input  rf_rd_en, rf_rd_addr, dump_valid, dump_idx, dump_data,
               dump_last, busy, done
    );

endinterface

// File: rtl/mips32_reg_dump.sv
// Post-halt register-file readout: walks R0..R(NUM_REGS-1) through a
// dedicated read port and emits one valid/ready beat per register.
module mips32_reg_dump
    import mips32_pkg::*;
#(
    parameter int unsigned NUM_REGS = REG_COUNT,
    parameter int unsigned DATA_W   = WORD_W,
    parameter int unsigned IDX_W    = REG_IDX_W
) (
    input  logic              clk1,
    input  logic              rst,
    mips32_reg_dump_if.master dif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    dump_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic              halted_q;
    logic              rd_en_q;
    logic [IDX_W-1:0]  rd_addr_q;
    logic              valid_q;
    logic [IDX_W-1:0]  beat_idx_q;
    logic [DATA_W-1:0] beat_data_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;

    assign dif.rf_rd_en   = rd_en_q;
    assign dif.rf_rd_addr = rd_addr_q;
    assign dif.dump_valid = valid_q;
    assign dif.dump_idx   = beat_idx_q;
    assign dif.dump_data  = beat_data_q;
    assign dif.dump_last  = last_q;
    assign dif.busy       = busy_q;
    assign dif.done       = done_q;

    // halted_q resets high so a core already halted out of reset needs a
    // fresh 0->1 edge before a dump starts.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            halted_q    <= 1'b1;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            valid_q     <= 1'b0;
            beat_idx_q  <= '0;
            beat_data_q <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            halted_q <= dif.halted;
            case (state)
                IDLE: begin
                    if (dif.halted && !halted_q) begin
                        idx       <= '0;
                        rd_addr_q <= '0;
                        rd_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    rd_en_q     <= 1'b0;
                    beat_data_q <= dif.rf_rd_data;
                    beat_idx_q  <= idx;
                    last_q      <= (idx == LAST_IDX);
                    valid_q     <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    if (valid_q && dif.dump_ready) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx       <= idx + 1'b1;
                            rd_addr_q <= idx + 1'b1;
                            rd_en_q   <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                DONE: begin
                    if (!dif.halted) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_reg_dump.sv
// Directed bench for mips32_reg_dump with a phase-2 register-file read model.
module tb_mips32_reg_dump;
    import mips32_pkg::*;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    mips32_reg_dump_if #(.DATA_W(WORD_W), .IDX_W(REG_IDX_W)) dif ();

    mips32_reg_dump #(
        .NUM_REGS(REG_COUNT),
        .DATA_W  (WORD_W),
        .IDX_W   (REG_IDX_W)
    ) dut (
        .clk1(clk1),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk1 = ~clk1;

    // Register file answers on the falling edge of a read cycle; garbage otherwise.
    logic [31:0] rf [32];
    always @(negedge clk1)
        dif.rf_rd_data <= dif.rf_rd_en ? rf[dif.rf_rd_addr] : 32'hDEAD_BEEF;

    int errors = 0;
    int checks = 0;

    int          got_n, got_done, got_en_c, got_valid_c, stall_bad;
    logic [4:0]  got_idx  [64];
    logic [31:0] got_data [64];
    logic        got_last [64];
    int          rd_cnt   [32];

    function automatic logic [31:0] expv(input int k);
        case (k)
            1: return 32'd10;
            2: return 32'd20;
            3: return 32'd25;
            4: return 32'd30;
            5: return 32'd55;
            default: return 32'(k);
        endcase
    endfunction

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    // Raises halted (caller guarantees it was low) and collects accepted beats.
    task automatic run_dump(input bit stall, input int fall_at);
        bit pv, pr, pl;
        logic [4:0]  pi;
        logic [31:0] pd;
        pv = 0; pr = 0; pl = 0; pi = '0; pd = '0;
        got_n = 0; got_done = -1; got_en_c = -1; got_valid_c = -1; stall_bad = 0;
        for (int i = 0; i < 32; i++) rd_cnt[i] = 0;
        dif.halted     = 1'b1;
        dif.dump_ready = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            tick;
            if (dif.rf_rd_en) begin
                rd_cnt[dif.rf_rd_addr]++;
                if (got_en_c < 0) got_en_c = c;
            end
            if (dif.dump_valid && got_valid_c < 0) got_valid_c = c;
            if (dif.done) begin
                got_done = c;
                break;
            end
            if (pv && !pr && (!dif.dump_valid || dif.dump_idx !== pi ||
                              dif.dump_data !== pd || dif.dump_last !== pl))
                stall_bad++;
            if (stall) dif.dump_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (dif.dump_valid && dif.dump_ready && got_n < 64) begin
                got_idx[got_n]  = dif.dump_idx;
                got_data[got_n] = dif.dump_data;
                got_last[got_n] = dif.dump_last;
                got_n++;
                if (int'(dif.dump_idx) == fall_at) dif.halted = 1'b0;
            end
            pv = dif.dump_valid; pr = dif.dump_ready;
            pi = dif.dump_idx;   pd = dif.dump_data; pl = dif.dump_last;
        end
        dif.dump_ready = 1'b1;
    endtask

    task automatic test_reset;
        logic [74:0] outs;
        rst = 1'b1; dif.halted = 1'b0; dif.dump_ready = 1'b0;
        tick; tick;
        outs = {dif.rf_rd_en, dif.rf_rd_addr, dif.dump_valid, dif.dump_idx,
                dif.dump_data, dif.dump_last, dif.busy, dif.done};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_full_dump;
        int bad_beats, bad_reads;
        run_dump(1'b0, -1);
        checks++;
        if (got_en_c !== 1) begin
            errors++; $display("FAIL first_rd_en_cycle: got %0d expected 1", got_en_c);
        end
        checks++;
        if (got_valid_c !== 2) begin
            errors++; $display("FAIL first_valid_cycle: got %0d expected 2", got_valid_c);
        end
        checks++;
        if (got_done !== 65) begin
            errors++; $display("FAIL done_latency: got %0d expected 65", got_done);
        end
        checks++;
        if (got_n !== 32) begin
            errors++; $display("FAIL beat_count: got %0d expected 32", got_n);
        end
        bad_beats = 0;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (got_idx[k] !== 5'(k) || got_data[k] !== expv(k) || got_last[k] !== (k == 31)) begin
                errors++; bad_beats++;
                $display("FAIL beat_%0d: got idx=%0d data=%0d last=%b expected idx=%0d data=%0d last=%b",
                         k, got_idx[k], got_data[k], got_last[k], k, expv(k), k == 31);
            end
        end
        bad_reads = 0;
        for (int k = 0; k < 32; k++) if (rd_cnt[k] != 1) bad_reads++;
        checks++;
        if (bad_reads !== 0) begin
            errors++; $display("FAIL read_once: got %0d indices not read exactly once expected 0", bad_reads);
        end
        tick;
        checks++;
        if (dif.done !== 1'b1 || dif.busy !== 1'b0) begin
            errors++; $display("FAIL done_held: got done=%b busy=%b expected done=1 busy=0", dif.done, dif.busy);
        end
        dif.halted = 1'b0;
        tick;
        checks++;
        if (dif.done !== 1'b0) begin
            errors++; $display("FAIL done_drop: got %b expected 0", dif.done);
        end
    endtask

    task automatic test_stall;
        int bad_order, bad_reads;
        run_dump(1'b1, -1);
        checks++;
        if (got_n !== 32 || got_done < 0) begin
            errors++; $display("FAIL stall_count: got beats=%0d done_cycle=%0d expected 32 and done", got_n, got_done);
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++; $display("FAIL stall_stable: got %0d changed beats expected 0", stall_bad);
        end
        bad_order = 0;
        for (int k = 0; k < 32; k++)
            if (got_idx[k] !== 5'(k) || got_data[k] !== expv(k)) bad_order++;
        checks++;
        if (bad_order !== 0) begin
            errors++; $display("FAIL stall_order: got %0d wrong beats expected 0", bad_order);
        end
        bad_reads = 0;
        for (int k = 0; k < 32; k++) if (rd_cnt[k] != 1) bad_reads++;
        checks++;
        if (bad_reads !== 0) begin
            errors++; $display("FAIL stall_read_once: got %0d bad indices expected 0", bad_reads);
        end
        dif.halted = 1'b0;
        tick;
    endtask

    task automatic test_halted_during_reset;
        int activity;
        dif.halted = 1'b1; rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        activity = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (dif.dump_valid || dif.rf_rd_en || dif.busy) activity++;
        end
        checks++;
        if (activity !== 0) begin
            errors++; $display("FAIL no_dump_after_reset: got %0d active cycles expected 0", activity);
        end
        dif.halted = 1'b0;
        tick;
        run_dump(1'b0, -1);
        checks++;
        if (got_n !== 32 || got_done !== 65 || got_data[31] !== 32'd31) begin
            errors++; $display("FAIL dump_after_fresh_edge: got beats=%0d done=%0d data31=%0d expected 32 65 31",
                               got_n, got_done, got_data[31]);
        end
        dif.halted = 1'b0;
        tick;
    endtask

    task automatic test_halt_fall_mid;
        run_dump(1'b0, 7);
        checks++;
        if (got_n !== 32 || got_idx[31] !== 5'd31 || got_last[31] !== 1'b1) begin
            errors++; $display("FAIL fall_mid_complete: got beats=%0d last_idx=%0d last=%b expected 32 31 1",
                               got_n, got_idx[31], got_last[31]);
        end
        checks++;
        if (got_done !== 65) begin
            errors++; $display("FAIL fall_mid_done: got %0d expected 65", got_done);
        end
        tick;
        checks++;
        if (dif.done !== 1'b0 || dif.busy !== 1'b0 || dif.dump_valid !== 1'b0) begin
            errors++; $display("FAIL done_pulse_one: got done=%b busy=%b valid=%b expected 0 0 0",
                               dif.done, dif.busy, dif.dump_valid);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        bit hit;
        int activity;
        logic [74:0] outs;
        dif.halted = 1'b1; dif.dump_ready = 1'b1; hit = 0;
        for (int c = 0; c < 100; c++) begin
            tick;
            if (dif.dump_valid && dif.dump_idx == 5'd12) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (hit !== 1'b1) begin
            errors++; $display("FAIL reach_idx12: got %b expected 1", hit);
        end
        rst = 1'b1;
        tick;
        outs = {dif.rf_rd_en, dif.rf_rd_addr, dif.dump_valid, dif.dump_idx,
                dif.dump_data, dif.dump_last, dif.busy, dif.done};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        activity = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (dif.dump_valid || dif.rf_rd_en) activity++;
        end
        checks++;
        if (activity !== 0) begin
            errors++; $display("FAIL no_beats_after_reset: got %0d active cycles expected 0", activity);
        end
        dif.halted = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [31:0] first [32];
        int bad;
        run_dump(1'b0, -1);
        for (int k = 0; k < 32; k++) first[k] = got_data[k];
        checks++;
        if (got_n !== 32 || got_done !== 65) begin
            errors++; $display("FAIL b2b_first: got beats=%0d done=%0d expected 32 65", got_n, got_done);
        end
        dif.halted = 1'b0;
        tick;
        run_dump(1'b0, -1);
        checks++;
        if (got_n !== 32 || got_idx[0] !== 5'd0) begin
            errors++; $display("FAIL b2b_restart: got beats=%0d first_idx=%0d expected 32 0", got_n, got_idx[0]);
        end
        bad = 0;
        for (int k = 0; k < 32; k++)
            if (got_data[k] !== first[k] || got_data[k] !== expv(k) || got_idx[k] !== 5'(k)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL b2b_data: got %0d differing beats expected 0", bad);
        end
        dif.halted = 1'b0;
        tick;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'(k);
        rf[1] = 32'd10; rf[2] = 32'd20; rf[3] = 32'd25; rf[4] = 32'd30; rf[5] = 32'd55;
        dif.halted = 1'b0;
        dif.dump_ready = 1'b0;
        test_reset;
        test_full_dump;
        test_stall;
        test_halted_during_reset;
        test_halt_fall_mid;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
